// File: rtl/turf_arb_pkg.sv
// turf_arb_pkg: state encoding, master indices and default timeout read data
// shared by the TURF register-port arbiter and its timeout helper.
package turf_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEADDEAD;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/turf_arb_timeout.sv
// turf_arb_timeout: counts BUSY cycles from the grant and flags expiry once the
// count reaches TIMEOUT_CYCLES. Only instantiated when TURF_ARB_TIMEOUT_EN is defined.
module turf_arb_timeout
  import turf_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic busy,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  // Saturates at LIMIT so a stuck BUSY never wraps back to a small count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (busy && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = busy && (count == LIMIT);

endmodule

// File: rtl/turf_bus_arbiter.sv
// turf_bus_arbiter: round-robin sharing of the TURF register port between the PLX
// host (M0) and housekeeping (M1). Optional ack timeout under `TURF_ARB_TIMEOUT_EN.
module turf_bus_arbiter
  import turf_arb_pkg::*;
#(
  parameter int ADDR_BITS = 6,
  parameter int DATA_BITS = 32,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter logic [DATA_BITS-1:0] TIMEOUT_DATA = DATA_BITS'(TIMEOUT_DATA_DEF)
) (
  input  logic                 clk_i,
  input  logic                 nrst_i,
  input  logic                 m0_wr_i,
  input  logic                 m0_rd_i,
  input  logic [ADDR_BITS-1:0] m0_addr_i,
  input  logic [DATA_BITS-1:0] m0_dat_i,
  output logic [DATA_BITS-1:0] m0_dat_o,
  output logic                 m0_ack_o,
  input  logic                 m1_wr_i,
  input  logic                 m1_rd_i,
  input  logic [ADDR_BITS-1:0] m1_addr_i,
  input  logic [DATA_BITS-1:0] m1_dat_i,
  output logic [DATA_BITS-1:0] m1_dat_o,
  output logic                 m1_ack_o,
  output logic                 turf_wr_o,
  output logic                 turf_rd_o,
  output logic [ADDR_BITS-1:0] turf_addr_o,
  output logic [DATA_BITS-1:0] turf_dat_o,
  input  logic [DATA_BITS-1:0] turf_dat_i,
  input  logic                 turf_ack_i,
  output logic [1:0]           grant_o,
  output logic                 err_o,
  input  logic                 err_clr_i
);

  arb_state_t state, state_next;

  logic owner;
  logic prio;
  logic req0, req1;
  logic grant_go, pick, done;
  logic timeout_hit;
  logic sel_wr, sel_rd;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [DATA_BITS-1:0] sel_dat;
  logic [DATA_BITS-1:0] resp_dat;

  assign req0 = m0_wr_i | m0_rd_i;
  assign req1 = m1_wr_i | m1_rd_i;

  assign sel_wr   = (pick == M1) ? m1_wr_i   : m0_wr_i;
  assign sel_rd   = (pick == M1) ? m1_rd_i   : m0_rd_i;
  assign sel_addr = (pick == M1) ? m1_addr_i : m0_addr_i;
  assign sel_dat  = (pick == M1) ? m1_dat_i  : m0_dat_i;

  // A forced completion returns the marker word; a real write ack returns zero.
  assign resp_dat = turf_ack_i ? (turf_rd_o ? turf_dat_i : '0) : TIMEOUT_DATA;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    grant_go   = 1'b0;
    pick       = M0;
    done       = 1'b0;
    m0_ack_o   = 1'b0;
    m1_ack_o   = 1'b0;
    m0_dat_o   = '0;
    m1_dat_o   = '0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant_go   = 1'b1;
          pick       = (req0 && req1) ? prio : (req0 ? M0 : M1);
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (turf_ack_i || timeout_hit) begin
          done       = 1'b1;
          state_next = IDLE;
          if (owner == M1) begin
            m1_ack_o = 1'b1;
            m1_dat_o = resp_dat;
          end else begin
            m0_ack_o = 1'b1;
            m0_dat_o = resp_dat;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The port is loaded once at grant and held untouched until completion.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      turf_wr_o   <= 1'b0;
      turf_rd_o   <= 1'b0;
      turf_addr_o <= '0;
      turf_dat_o  <= '0;
      grant_o     <= '0;
      owner       <= M0;
      prio        <= M0;
    end else if (grant_go) begin
      turf_wr_o     <= sel_wr;
      turf_rd_o     <= sel_rd & ~sel_wr;
      turf_addr_o   <= sel_addr;
      turf_dat_o    <= sel_dat;
      grant_o       <= '0;
      grant_o[pick] <= 1'b1;
      owner         <= pick;
      prio          <= ~pick;
    end else if (done) begin
      turf_wr_o <= 1'b0;
      turf_rd_o <= 1'b0;
      grant_o   <= '0;
    end
  end

`ifdef TURF_ARB_TIMEOUT_EN
  turf_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk_i),
    .rst_n  (nrst_i),
    .start  (grant_go),
    .busy   (state == BUSY),
    .expired(timeout_hit)
  );

  // A real ack in the expiry cycle wins, so only a true timeout sets the flag.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      err_o <= 1'b0;
    end else if (timeout_hit && !turf_ack_i) begin
      err_o <= 1'b1;
    end else if (err_clr_i) begin
      err_o <= 1'b0;
    end
  end
`else
  logic unused_cfg;

  assign timeout_hit = 1'b0;
  assign err_o       = 1'b0;
  assign unused_cfg  = err_clr_i ^ (TIMEOUT_CYCLES == 0);
`endif

endmodule
